vdp_dot_timing: RTL and testbench



---
 rtl/vdp_dot_timing_if.sv | 27 ++
 rtl/vdp_dot_timing.sv | 110 +++++++++++
 tb/tb_vdp_dot_timing.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_dot_timing_if.sv
// Raster timing bundle: frame-format register inputs in, dot/line timing out.
interface vdp_dot_timing_if;
  logic       REG_R9_PAL_MODE;
  logic       REG_R9_LN;
  logic [1:0] DOTSTATE;
  logic [2:0] EIGHTDOTSTATE;
  logic [8:0] DOTCOUNTERX;
  logic [8:0] DOTCOUNTERYP;
  logic       BWINDOW_X;
  logic       BWINDOW_Y;
  logic       LINE_END;
  logic       FRAME_END;
  logic       VINT_PULSE;
  logic       FIELD;

  modport master (
    input  REG_R9_PAL_MODE, REG_R9_LN,
    output DOTSTATE, EIGHTDOTSTATE, DOTCOUNTERX, DOTCOUNTERYP,
           BWINDOW_X, BWINDOW_Y, LINE_END, FRAME_END, VINT_PULSE, FIELD
  );

  modport slave (
    output REG_R9_PAL_MODE, REG_R9_LN,
    input  DOTSTATE, EIGHTDOTSTATE, DOTCOUNTERX, DOTCOUNTERYP,
           BWINDOW_X, BWINDOW_Y, LINE_END, FRAME_END, VINT_PULSE, FIELD
  );
endinterface

// File: rtl/vdp_dot_timing.sv
// VDP raster timing: four-phase dot strobe, X/Y dot counters, display windows
// and line/frame/vertical-interrupt pulses. All outputs come straight from flops.
module vdp_dot_timing #(
  parameter logic [8:0] H_FIRST   = 9'h1F8,
  parameter logic [8:0] H_LAST    = 9'd341,
  parameter logic [8:0] V_FIRST   = 9'h1F8,
  parameter logic [8:0] V_LAST_60 = 9'd264,
  parameter logic [8:0] V_LAST_50 = 9'd314
) (
  input  logic             CLK21M,
  input  logic             RESET_N,
  vdp_dot_timing_if.master tmg
);

  typedef enum logic [1:0] {
    DS_00 = 2'b00,
    DS_01 = 2'b01,
    DS_11 = 2'b11,
    DS_10 = 2'b10
  } dot_state_t;

  dot_state_t ds, ds_next;
  logic [8:0] x, x_next, y, y_next;
  logic [8:0] v_last, vint_line, y_win_end;
  logic [2:0] eds;
  logic       pal_q, ln_q, ln_next, init_q, shadow_load;
  logic       line_end_now, line_end_next, y_wrap;
  logic       bwx_q, bwy_q, line_end_q, frame_end_q, vint_q, field_q;

  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) ds <= DS_10;
    else          ds <= ds_next;
  end

  always_comb begin
    ds_next = ds;
    case (ds)
      DS_10:   ds_next = DS_00;
      DS_00:   ds_next = DS_01;
      DS_01:   ds_next = DS_11;
      default: ds_next = DS_10;
    endcase
  end

  always_comb begin
    x_next = x;
    if (ds == DS_11) x_next = (x == H_LAST) ? H_FIRST : x + 9'd1;

    v_last       = pal_q ? V_LAST_50 : V_LAST_60;
    vint_line    = ln_q ? 9'd211 : 9'd191;
    line_end_now = (ds == DS_10) && (x == H_LAST);
    y_wrap       = line_end_now && (y == v_last);

    y_next = y;
    if (line_end_now) y_next = y_wrap ? V_FIRST : y + 9'd1;

    // shadows follow the inputs on the first clock out of reset and at each wrap
    shadow_load = init_q || y_wrap;
    ln_next     = shadow_load ? tmg.REG_R9_LN : ln_q;
    y_win_end   = ln_next ? 9'd212 : 9'd192;

    // pulses are registered from next state so they land in the cycle the
    // line-end condition itself holds
    line_end_next = (ds == DS_11) && (x_next == H_LAST);
  end

  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) begin
      x           <= H_FIRST;
      y           <= V_FIRST;
      eds         <= '0;
      pal_q       <= 1'b0;
      ln_q        <= 1'b0;
      init_q      <= 1'b1;
      bwx_q       <= 1'b0;
      bwy_q       <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      vint_q      <= 1'b0;
      field_q     <= 1'b0;
    end else begin
      x      <= x_next;
      y      <= y_next;
      init_q <= 1'b0;
      if (ds == DS_10) eds <= x[2:0];
      if (shadow_load) begin
        pal_q <= tmg.REG_R9_PAL_MODE;
        ln_q  <= tmg.REG_R9_LN;
      end
      bwx_q       <= (x_next < 9'd256);
      bwy_q       <= (y_next < y_win_end);
      line_end_q  <= line_end_next;
      frame_end_q <= line_end_next && (y == v_last);
      vint_q      <= line_end_next && (y == vint_line);
      if (y_wrap) field_q <= ~field_q;
    end
  end

  assign tmg.DOTSTATE      = ds;
  assign tmg.EIGHTDOTSTATE = eds;
  assign tmg.DOTCOUNTERX   = x;
  assign tmg.DOTCOUNTERYP  = y;
  assign tmg.BWINDOW_X     = bwx_q;
  assign tmg.BWINDOW_Y     = bwy_q;
  assign tmg.LINE_END      = line_end_q;
  assign tmg.FRAME_END     = frame_end_q;
  assign tmg.VINT_PULSE    = vint_q;
  assign tmg.FIELD         = field_q;

endmodule

// File: tb/tb_vdp_dot_timing.sv
// Bench for vdp_dot_timing: full-width line checks on a default instance,
// frame/interrupt checks on a short-line instance via an event scoreboard.
module tb_vdp_dot_timing;

  logic CLK21M = 1'b0;
  logic rst_h_n, rst_v_n;
  always #5 CLK21M = ~CLK21M;

  vdp_dot_timing_if bh();
  vdp_dot_timing_if bv();

  vdp_dot_timing u_h (.CLK21M(CLK21M), .RESET_N(rst_h_n), .tmg(bh));
  // 16-clock lines keep whole frames short
  vdp_dot_timing #(.H_LAST(9'h1FB)) u_v (.CLK21M(CLK21M), .RESET_N(rst_v_n), .tmg(bv));

  localparam int LINE_V = 16;
  localparam int FR60_V = 273 * LINE_V;
  localparam logic [28:0] RST_ALL = {2'b10, 3'd0, 9'h1F8, 9'h1F8, 6'd0};

  typedef struct {
    int         cyc;
    logic [1:0] ds;
    logic [8:0] x;
    logic [2:0] eds;
    logic       bwx;
    logic       le;
    logic [8:0] y;
  } vec_t;

  typedef struct {
    logic       kind;   // 0 = VINT_PULSE, 1 = FRAME_END
    logic [8:0] y;
    int         cyc;
    int         bwy;
    logic       field;
  } ev_t;

  vec_t tbl[$];
  ev_t  sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_v;
  int   n_h, bwx_cnt, le_cnt, bwy_cnt;
  logic v_watch;

  logic [28:0] h_all, v_all;
  assign h_all = {bh.DOTSTATE, bh.EIGHTDOTSTATE, bh.DOTCOUNTERX, bh.DOTCOUNTERYP,
                  bh.BWINDOW_X, bh.BWINDOW_Y, bh.LINE_END, bh.FRAME_END, bh.VINT_PULSE, bh.FIELD};
  assign v_all = {bv.DOTSTATE, bv.EIGHTDOTSTATE, bv.DOTCOUNTERX, bv.DOTCOUNTERYP,
                  bv.BWINDOW_X, bv.BWINDOW_Y, bv.LINE_END, bv.FRAME_END, bv.VINT_PULSE, bv.FIELD};

  always @(posedge CLK21M) begin
    if (!rst_v_n) cyc_v <= 0;
    else          cyc_v <= cyc_v + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h required=0x%0h", nm, got, exp);
    end
  endtask

  task automatic add_vec(input int c, input int ds, input int x, input int eds,
                         input int bwx, input int le, input int y);
    vec_t v;
    v.cyc = c;       v.ds = 2'(ds);   v.x = 9'(x);  v.eds = 3'(eds);
    v.bwx = 1'(bwx); v.le = 1'(le);   v.y = 9'(y);
    tbl.push_back(v);
  endtask

  function automatic int ev_cyc(input int fstart, input int y);
    return fstart + 12 + LINE_V * (y + 8);
  endfunction

  task automatic push_frame(input int fstart, input logic ln, input logic pal, input logic fld);
    ev_t e;
    int vl, fl;
    vl = ln ? 211 : 191;
    fl = pal ? 314 : 264;
    e.kind = 1'b0; e.y = 9'(vl); e.cyc = ev_cyc(fstart, vl); e.bwy = 0; e.field = 1'b0;
    sb.push_back(e);
    e.kind = 1'b1; e.y = 9'(fl); e.cyc = ev_cyc(fstart, fl);
    e.bwy = (ln ? 212 : 192) * LINE_V; e.field = fld;
    sb.push_back(e);
  endtask

  task automatic chk_ev(input logic kind);
    ev_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL ev_unexpected kind=%0d got y=%0d cyc=%0d required no pulse",
               kind, bv.DOTCOUNTERYP, cyc_v);
      return;
    end
    e = sb.pop_front();
    if (e.kind !== kind || e.y !== bv.DOTCOUNTERYP || e.cyc != cyc_v || bv.LINE_END !== 1'b1 ||
        (kind && (e.bwy != bwy_cnt || e.field !== bv.FIELD))) begin
      n_err++;
      $display("FAIL ev_%s got kind=%0d y=%0d cyc=%0d le=%0b bwy=%0d field=%0b required kind=%0d y=%0d cyc=%0d le=1 bwy=%0d field=%0b",
               kind ? "frame" : "vint", kind, bv.DOTCOUNTERYP, cyc_v, bv.LINE_END, bwy_cnt,
               bv.FIELD, e.kind, e.y, e.cyc, e.bwy, e.field);
    end
  endtask

  task automatic step_h();
    @(negedge CLK21M);
    n_h++;
    if (bh.BWINDOW_X) bwx_cnt++;
    if (bh.LINE_END)  le_cnt++;
  endtask

  task automatic wait_v_y(input logic [8:0] y, input int lim);
    int k;
    k = 0;
    while (bv.DOTCOUNTERYP !== y && k < lim) begin
      @(negedge CLK21M);
      k++;
    end
    chk($sformatf("wait_v_y%0d", y), 32'(bv.DOTCOUNTERYP), 32'(y));
  endtask

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog got=timeout required=finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    rst_h_n = 1'b1; rst_v_n = 1'b1; v_watch = 1'b0;
    bh.REG_R9_PAL_MODE = 1'b0; bh.REG_R9_LN = 1'b0;
    bv.REG_R9_PAL_MODE = 1'b0; bv.REG_R9_LN = 1'b0;
    n_h = 0; bwx_cnt = 0; le_cnt = 0; bwy_cnt = 0;

    // {cycles after release, DOTSTATE, X, EIGHTDOTSTATE, BWINDOW_X, LINE_END, Y}
    add_vec(   0, 2, 504, 0, 0, 0, 504);
    add_vec(   1, 0, 504, 0, 0, 0, 504);
    add_vec(   2, 1, 504, 0, 0, 0, 504);
    add_vec(   3, 3, 504, 0, 0, 0, 504);
    add_vec(   4, 2, 505, 0, 0, 0, 504);
    add_vec(   5, 0, 505, 1, 0, 0, 504);
    add_vec(  31, 3, 511, 7, 0, 0, 504);
    add_vec(  32, 2,   0, 7, 1, 0, 504);
    add_vec(  33, 0,   0, 0, 1, 0, 504);
    add_vec(  37, 0,   1, 1, 1, 0, 504);
    add_vec(1055, 3, 255, 7, 1, 0, 504);
    add_vec(1056, 2, 256, 7, 0, 0, 504);
    add_vec(1395, 3, 340, 4, 0, 0, 504);
    add_vec(1396, 2, 341, 4, 0, 1, 504);
    add_vec(1397, 0, 341, 5, 0, 0, 505);
    add_vec(1399, 3, 341, 5, 0, 0, 505);
    add_vec(1400, 2, 504, 5, 0, 0, 505);
    add_vec(1401, 0, 504, 0, 0, 0, 505);
    add_vec(2796, 2, 341, 4, 0, 1, 505);
    add_vec(2797, 0, 341, 5, 0, 0, 506);

    // frame-event monitor for the short-line instance
    fork
      forever begin
        @(negedge CLK21M);
        if (rst_v_n) begin
          if (bv.BWINDOW_Y)  bwy_cnt++;
          if (bv.VINT_PULSE) chk_ev(1'b0);
          if (bv.FRAME_END) begin
            chk_ev(1'b1);
            bwy_cnt = 0;
          end
        end else begin
          bwy_cnt = 0;
          if (v_watch)
            chk("v_pulse_in_reset", 32'({bv.LINE_END, bv.FRAME_END, bv.VINT_PULSE}), 32'd0);
        end
      end
    join_none

    #1 rst_h_n = 1'b0; rst_v_n = 1'b0;
    #2;
    chk("h_reset_state", 32'(h_all), 32'(RST_ALL));
    chk("v_reset_state", 32'(v_all), 32'(RST_ALL));
    repeat (3) @(negedge CLK21M);
    rst_h_n = 1'b1;

    foreach (tbl[i]) begin
      while (n_h < tbl[i].cyc) step_h();
      chk($sformatf("h_vec%0d_n%0d", i, tbl[i].cyc),
          32'({bh.DOTSTATE, bh.DOTCOUNTERX, bh.EIGHTDOTSTATE, bh.BWINDOW_X, bh.LINE_END, bh.DOTCOUNTERYP}),
          32'({tbl[i].ds, tbl[i].x, tbl[i].eds, tbl[i].bwx, tbl[i].le, tbl[i].y}));
    end
    chk("h_bwx_clocks_2lines", 32'(bwx_cnt), 32'd2048);
    chk("h_line_end_count", 32'(le_cnt), 32'd2);

    // mid-line reset on the full-width instance
    while (n_h < 3313) step_h();
    chk("h_x_before_reset", 32'(bh.DOTCOUNTERX), 32'd120);
    #2 rst_h_n = 1'b0;
    #1 chk("h_async_reset", 32'(h_all), 32'(RST_ALL));
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK21M);
      chk($sformatf("h_in_reset%0d", k), 32'(h_all), 32'(RST_ALL));
    end
    rst_h_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK21M);
      chk($sformatf("h_exit_pulse_n%0d", k),
          32'({bh.LINE_END, bh.FRAME_END, bh.VINT_PULSE}), 32'd0);
    end
    chk("h_restart", 32'({bh.DOTSTATE, bh.DOTCOUNTERX, bh.DOTCOUNTERYP}),
        32'({2'b10, 9'd505, 9'd504}));

    // frames on the short-line instance
    @(negedge CLK21M);
    rst_v_n = 1'b1;
    push_frame(0, 1'b0, 1'b0, 1'b0);
    wait_v_y(9'd264, 6000);
    wait_v_y(9'd100, 3000);
    bv.REG_R9_PAL_MODE = 1'b1;
    bv.REG_R9_LN       = 1'b1;
    push_frame(FR60_V,     1'b0, 1'b0, 1'b1);
    push_frame(2 * FR60_V, 1'b1, 1'b1, 1'b0);
    wait_v_y(9'd314, 10000);
    wait_v_y(9'd50, 2000);
    chk("v_sb_drained", 32'(sb.size()), 32'd0);

    // mid-frame reset on the short-line instance
    #2 rst_v_n = 1'b0;
    v_watch = 1'b1;
    #1 chk("v_async_reset", 32'(v_all), 32'(RST_ALL));
    repeat (3) @(negedge CLK21M);
    chk("v_in_reset", 32'(v_all), 32'(RST_ALL));
    rst_v_n = 1'b1;
    v_watch = 1'b0;
    repeat (4) @(negedge CLK21M);
    chk("v_restart_x", 32'({bv.DOTSTATE, bv.DOTCOUNTERX, bv.DOTCOUNTERYP}),
        32'({2'b10, 9'd505, 9'd504}));
    repeat (9) @(negedge CLK21M);
    chk("v_restart_y", 32'(bv.DOTCOUNTERYP), 32'd505);
    repeat (40) @(negedge CLK21M);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
